// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator request dispatcher.
// Contents:
//   state_e  - dispatcher FSM states (IDLE, MOVE, DOOR)
//   FLOOR_W  - width of a floor number (floors 1..7, 0 = none)
//   NO_FLOOR - encoding for "no floor"
//   DIR_UP / DIR_DOWN - scan direction encodings
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_e;

    localparam int unsigned FLOOR_W = 3;

    localparam logic [FLOOR_W-1:0] NO_FLOOR = 3'b000;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/elevator_dispatcher_scan_picker.sv
// Combinational SCAN target picker: returns the nearest pending floor strictly beyond
// cur_floor in the current direction, or, if there is none, the nearest pending floor
// strictly beyond cur_floor in the opposite direction (with the direction flipped).
// Ports:
//   pending_i      - pending call set, bit i-1 = floor i
//   cur_floor_i    - current car position
//   dir_i          - current scan direction
//   next_floor_o   - chosen floor, NO_FLOOR when nothing qualifies
//   next_dir_o     - direction that reaches next_floor_o (dir_i when not found)
//   found_o        - a floor qualified
module scan_picker
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS = 7
) (
    input  logic [FLOORS-1:0]  pending_i,
    input  logic [FLOOR_W-1:0] cur_floor_i,
    input  logic               dir_i,
    output logic [FLOOR_W-1:0] next_floor_o,
    output logic               next_dir_o,
    output logic               found_o
);

    logic [FLOOR_W-1:0] up_floor;
    logic [FLOOR_W-1:0] dn_floor;
    logic               up_found;
    logic               dn_found;

    always_comb begin
        up_floor = NO_FLOOR;
        up_found = 1'b0;
        dn_floor = NO_FLOOR;
        dn_found = 1'b0;
        // Descending walk: the last hit is the smallest floor above the car.
        for (int i = FLOORS; i >= 1; i--) begin
            if (pending_i[i-1] && (FLOOR_W'(i) > cur_floor_i)) begin
                up_floor = FLOOR_W'(i);
                up_found = 1'b1;
            end
        end
        // Ascending walk: the last hit is the largest floor below the car.
        for (int i = 1; i <= FLOORS; i++) begin
            if (pending_i[i-1] && (FLOOR_W'(i) < cur_floor_i)) begin
                dn_floor = FLOOR_W'(i);
                dn_found = 1'b1;
            end
        end
    end

    always_comb begin
        next_floor_o = NO_FLOOR;
        next_dir_o   = dir_i;
        found_o      = 1'b0;
        if (dir_i == DIR_UP) begin
            if (up_found) begin
                next_floor_o = up_floor;
                found_o      = 1'b1;
            end else if (dn_found) begin
                next_floor_o = dn_floor;
                next_dir_o   = DIR_DOWN;
                found_o      = 1'b1;
            end
        end else begin
            if (dn_found) begin
                next_floor_o = dn_floor;
                found_o      = 1'b1;
            end else if (up_found) begin
                next_floor_o = up_floor;
                next_dir_o   = DIR_UP;
                found_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_dispatcher.sv
// Single-car elevator request scheduler. Collects floor calls into a pending set,
// issues one target floor at a time in SCAN order, and holds the door open for
// DOOR_CYCLES cycles on each arrival while clearing the served call.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   call_valid_i   - call strobe
//   call_floor_i   - requested floor (0 or >FLOORS ignored)
//   cur_floor_i    - current car position
//   at_floor_i     - car stopped at its target
//   target_o       - issued floor, NO_FLOOR when none
//   dir_o          - scan direction (0 up, 1 down)
//   door_open_o    - high during the dwell
//   pending_o      - pending call set, bit i-1 = floor i
//   busy_o         - high in every state except IDLE
module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS      = 7,
    parameter int unsigned DOOR_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               call_valid_i,
    input  logic [FLOOR_W-1:0] call_floor_i,
    input  logic [FLOOR_W-1:0] cur_floor_i,
    input  logic               at_floor_i,
    output logic [FLOOR_W-1:0] target_o,
    output logic               dir_o,
    output logic               door_open_o,
    output logic [FLOORS-1:0]  pending_o,
    output logic               busy_o
);

    localparam int unsigned      CNT_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL = CNT_W'(DOOR_CYCLES);

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] target_q, target_d;
    logic               dir_q, dir_d;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [FLOORS-1:0]  call_mask;
    logic [FLOORS-1:0]  cur_mask;
    logic [FLOORS-1:0]  set_mask;
    logic [FLOORS-1:0]  clr_mask;
    logic [FLOOR_W-1:0] pick_floor;
    logic               pick_dir;
    logic               pick_found;
    logic               nearer;

    // One-hot decodes; out-of-range floors match no bit and are thereby ignored.
    for (genvar g = 0; g < FLOORS; g++) begin : g_mask
        assign call_mask[g] = (call_floor_i == FLOOR_W'(g + 1));
        assign cur_mask[g]  = (cur_floor_i == FLOOR_W'(g + 1));
    end

    scan_picker #(
        .FLOORS (FLOORS)
    ) u_picker (
        .pending_i    (pending_q),
        .cur_floor_i  (cur_floor_i),
        .dir_i        (dir_q),
        .next_floor_o (pick_floor),
        .next_dir_o   (pick_dir),
        .found_o      (pick_found)
    );

    always_comb begin
        set_mask = '0;
        if (call_valid_i) begin
            // A call for the car's own floor while the door is open is already served.
            set_mask = (state_q == DOOR) ? (call_mask & ~cur_mask) : call_mask;
        end
    end

    always_comb begin
        nearer = 1'b0;
        if (dir_q == DIR_UP) begin
            nearer = pick_floor < target_q;
        end else begin
            nearer = pick_floor > target_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        clr_mask = '0;
        unique case (state_q)
            IDLE: begin
                target_d = NO_FLOOR;
                if (|(pending_q & cur_mask)) begin
                    state_d  = DOOR;
                    clr_mask = cur_mask;
                    cnt_d    = DWELL;
                end else if (pick_found) begin
                    state_d  = MOVE;
                    target_d = pick_floor;
                    dir_d    = pick_dir;
                end
            end
            MOVE: begin
                if (at_floor_i && (cur_floor_i == target_q)) begin
                    state_d  = DOOR;
                    clr_mask = cur_mask;
                    target_d = NO_FLOOR;
                    cnt_d    = DWELL;
                end else if (pick_found && (pick_dir == dir_q) && nearer) begin
                    // Picker searched strictly beyond the car in dir_q, so this floor
                    // lies between the car and the current target.
                    target_d = pick_floor;
                end
            end
            DOOR: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Clear takes priority over a same-cycle set of the same floor.
        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            target_q  <= NO_FLOOR;
            dir_q     <= DIR_UP;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign target_o    = target_q;
    assign dir_o       = dir_q;
    assign pending_o   = pending_q;
    assign door_open_o = (state_q == DOOR);
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed self-checking bench for elevator_dispatcher. Issued targets are checked
// against a scoreboard queue filled when the corresponding calls are driven.
module tb_elevator_dispatcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       call_valid = 1'b0;
    logic [2:0] call_floor = 3'd0;
    logic [2:0] cur_floor = 3'd1;
    logic       at_floor = 1'b0;
    logic [2:0] target;
    logic       dir;
    logic       door_open;
    logic [6:0] pending;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [2:0] sb_q[$];

    elevator_dispatcher #(
        .FLOORS      (7),
        .DOOR_CYCLES (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .call_valid_i (call_valid),
        .call_floor_i (call_floor),
        .cur_floor_i  (cur_floor),
        .at_floor_i   (at_floor),
        .target_o     (target),
        .dir_o        (dir),
        .door_open_o  (door_open),
        .pending_o    (pending),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the issued target against the oldest scoreboard entry.
    task automatic pop_target(input string tag);
        logic [2:0] exp;
        exp = 3'd0;
        if (sb_q.size() != 0) exp = sb_q.pop_front();
        check(tag, 32'(target), 32'(exp));
    endtask

    task automatic call(input logic [2:0] f);
        call_valid = 1'b1;
        call_floor = f;
        cyc();
        call_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        call_valid = 1'b0;
        at_floor   = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic dwell(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, "_door"}, 32'(door_open), 32'd1);
            check({tag, "_tgt_in_door"}, 32'(target), 32'd0);
            cyc();
        end
        check({tag, "_door_closed"}, 32'(door_open), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state held with no calls.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            check("rst_target", 32'(target), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_door", 32'(door_open), 32'd0);
            check("rst_pending", 32'(pending), 32'd0);
            cyc();
        end

        // Single call from floor 1 to 5.
        cur_floor = 3'd1;
        sb_q.push_back(3'd5);
        call(3'd5);
        check("c5_pending", 32'(pending), 32'b0010000);
        check("c5_tgt_early", 32'(target), 32'd0);
        cyc();
        pop_target("c5_target");
        check("c5_dir", 32'(dir), 32'd0);
        check("c5_busy", 32'(busy), 32'd1);
        cur_floor = 3'd5;
        at_floor  = 1'b1;
        cyc();
        at_floor = 1'b0;
        check("c5_pend_clr", 32'(pending), 32'd0);
        dwell("c5");

        // Calls 6 then 2 from floor 4: up first, then reverse.
        do_reset();
        cur_floor = 3'd4;
        sb_q.push_back(3'd6);
        call(3'd6);
        sb_q.push_back(3'd2);
        call(3'd2);
        pop_target("scan_t6");
        check("scan_pend", 32'(pending), 32'b0100010);
        cur_floor = 3'd6;
        at_floor  = 1'b1;
        cyc();
        at_floor = 1'b0;
        check("scan_pend6", 32'(pending), 32'b0000010);
        dwell("scan");
        cyc();
        pop_target("scan_t2");
        check("scan_dir", 32'(dir), 32'd1);

        // Retarget toward a nearer call, far call kept.
        do_reset();
        cur_floor = 3'd2;
        sb_q.push_back(3'd7);
        call(3'd7);
        cyc();
        pop_target("rt_t7");
        cur_floor = 3'd3;
        sb_q.push_back(3'd4);
        call(3'd4);
        check("rt_hold7", 32'(target), 32'd7);
        cyc();
        pop_target("rt_t4");
        cur_floor = 3'd4;
        at_floor  = 1'b1;
        cyc();
        at_floor = 1'b0;
        check("rt_pend7", 32'(pending), 32'b1000000);
        dwell("rt");
        sb_q.push_back(3'd7);
        cyc();
        pop_target("rt_t7b");
        check("rt_dir", 32'(dir), 32'd0);

        // Call at the car's floor: straight to DOOR, clear wins, repeat ignored.
        do_reset();
        cur_floor  = 3'd3;
        call_valid = 1'b1;
        call_floor = 3'd3;
        cyc();
        check("here_pend", 32'(pending), 32'b0000100);
        cyc();
        check("here_clr_wins", 32'(pending), 32'd0);
        check("here_door", 32'(door_open), 32'd1);
        check("here_notgt", 32'(target), 32'd0);
        cyc();
        call_valid = 1'b0;
        check("here_ignored", 32'(pending), 32'd0);
        check("here_door2", 32'(door_open), 32'd1);
        cyc();
        check("here_door3", 32'(door_open), 32'd1);
        cyc();
        check("here_closed", 32'(door_open), 32'd0);
        cyc();
        check("here_stay_idle", 32'(busy), 32'd0);

        // Reset in MOVE heading down with floors 3 and 7 pending.
        do_reset();
        cur_floor = 3'd5;
        sb_q.push_back(3'd3);
        call(3'd3);
        call(3'd7);
        pop_target("mr_t3");
        check("mr_dir", 32'(dir), 32'd1);
        check("mr_pend", 32'(pending), 32'b1000100);
        check("mr_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mr_target", 32'(target), 32'd0);
        check("mr_pend0", 32'(pending), 32'd0);
        check("mr_dir0", 32'(dir), 32'd0);
        check("mr_idle", 32'(busy), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elevator_dispatcher.md
# elevator_dispatcher

Request scheduler that sits in front of the single-car elevator datapath. It collects floor calls from up to seven call buttons into a pending set and issues one target floor at a time using SCAN ordering: continue in the current direction, then reverse. It holds the door open for a fixed dwell on each arrival and clears the served call.

## Interface
- FLOORS, 7, number of floors; floors are numbered 1..FLOORS, and encoding 0 means none.
- DOOR_CYCLES, 3, door dwell length in clk cycles; must be ≥ 1.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  Synchronous, active-high. reset, clock clk.
- call_valid  in  1  call strobe; sampled each cycle.
- call_floor  in  3  requested floor; values 0 and >FLOORS are ignored.
- cur_floor  in  3  current car position from the elevator datapath (1..7).
- at_floor  in  1  car stopped at its target floor (datapath arrival flag).
- target  out  3  floor issued to the datapath; 3'b000 when there is no target.
- dir  out  1  scan direction: 0 = up, 1 = down.
- door_open  out  1  high during the dwell.
- pending  out  7  pending call set; bit i-1 represents floor i.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MOVE, DOOR.
- Reset values: state IDLE, target 0, dir 0, door_open 0, pending 0, busy 0, dwell counter 0.
- Call capture:
  - A valid call sets its pending bit at the next edge.
  - A call for a floor already pending has no effect.
- Target selection (next_target, evaluated on pending and cur_floor):
  - dir=0: the smallest pending floor > cur_floor.
  - dir=1: the largest pending floor < cur_floor.
  - If no floor qualifies in the current direction, flip dir and search the other side.
- IDLE:
  - If the pending bit for cur_floor is set: go to DOOR, clear that bit, load the dwell counter.
  - Else if pending ≠ 0: go to MOVE, latch target = next_target, update dir if it flipped.
  - Else stay in IDLE with target 0.
- MOVE:
  - Retarget: if a new pending floor lies strictly between cur_floor and target in direction dir, target becomes that nearer floor.
  - If at_floor=1 and cur_floor==target: go to DOOR, clear pending[target-1], set target to 0, load the dwell counter with DOOR_CYCLES.
- DOOR:
  - door_open=1.
  - The counter decrements each cycle; at 1, return to IDLE.
  - A call for cur_floor during DOOR is ignored; it is not latched.
- Simultaneous clear and set on the same floor in the same cycle: the clear wins.
- Reset mid-operation drops every pending call and the target on the next edge.

## Timing
- Call to pending bit: 1 cycle.
- Pending bit to target ≠ 0 from IDLE: 1 further cycle, so 2 cycles from call_valid.
- Arrival (at_floor && cur_floor==target) to door_open=1: 1 cycle. door_open stays high for exactly DOOR_CYCLES cycles.
- Next target is issued on the cycle after the DOOR→IDLE transition. It is never issued during DOOR.
- A retarget in MOVE takes effect on target 1 cycle after the nearer call's pending bit is set.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package elevator_pkg holds:
  - state enum {IDLE, MOVE, DOOR};
  - localparam FLOOR_W=3;
  - NO_FLOOR=3'b000;
  - DIR_UP=1'b0 and DIR_DOWN=1'b1.
- Sub-module scan_picker is purely combinational:
  - inputs pending, cur_floor, dir;
  - outputs next_floor, next_dir, found.
  - It is reused for the retarget check.
- The top level contains the FSM, the pending register, and the dwell counter.

## Test plan
- After reset with no calls: target=0, busy=0, door_open=0, pending=0 held for 10 cycles.
- cur_floor=1, call floor 5: pending=7'b0010000 at +1 cycle, target=5 and dir=0 at +2. Then cur_floor=5 with at_floor=1 → door_open high for 3 cycles, pending=0, and the FSM returns to IDLE.
- cur_floor=4, dir=0, calls 2 and 6 in the same burst: target=6 first. After serving 6: dir=1, target=2.
- MOVE toward 7 from floor 2 when a call for floor 4 arrives while cur_floor=3: target switches to 4. Floor 7 stays pending and is issued after the dwell at 4.
- Call for cur_floor=3 while in IDLE: DOOR is entered directly with no MOVE. A repeat call for 3 during the dwell leaves pending[2]=0.
- Reset asserted in MOVE with pending=7'b1000100: on the next edge state=IDLE, target=0, pending=0, dir=0.
